// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM
// states, ALUOp codes, datapath mux selects and the per-state control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR_PC  = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_READ      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  // fetch marks the state whose IRWrite/PCUpdate follow the memory handshake;
  // pc_update covers only the unconditional jump writes.
  typedef struct packed {
    alu_op_t     alu_op;
    src_a_t      src_a;
    src_b_t      src_b;
    result_src_t result_src;
    logic        adr_src;
    logic        fetch;
    logic        pc_update;
    logic        branch;
    logic        reg_write;
    logic        mem_write;
    logic        illegal;
  } ctrl_t;

  // Moore decode of one state into its control bundle; anything not set is 0.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.src_b      = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
        c.fetch      = 1'b1;
      end
      S_DECODE: begin
        c.src_a = SRCA_OLDPC;
        c.src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = RES_READ;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.src_a  = SRCA_RS1;
        c.src_b  = SRCB_IMM;
        c.alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.src_a  = SRCA_RS1;
        c.alu_op = ALUOP_SUB;
        c.branch = 1'b1;
      end
      S_JAL, S_JALR_PC: begin
        c.src_a     = SRCA_OLDPC;
        c.src_b     = SRCB_FOUR;
        c.pc_update = 1'b1;
      end
      S_JALR: begin
        c.src_a = SRCA_RS1;
        c.src_b = SRCB_IMM;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Picks the immediate format for the extender straight from the opcode.
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  // Opcode to immediate format; unknown opcodes fall back to the I format.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LOAD, OP_JALR, OP_ITYPE: imm_src = IMM_I;
      OP_STORE:                   imm_src = IMM_S;
      OP_BRANCH:                  imm_src = IMM_B;
      OP_JAL:                     imm_src = IMM_J;
      default:                    imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle RV32I core. Walks each instruction
// through fetch/decode/execute/memory/writeback, stalling on mem_ready.
module multicycle_main_control
  import riscv_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       illegal_instr,
  output logic [3:0] state
);

  logic   ready;
  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_view;

  // With single-cycle memory the handshake is permanently complete.
  assign ready = USE_MEM_READY ? mem_ready : 1'b1;

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (ImmSrc)
  );

  // Next-state selection; stray encodings recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALR_PC;
      S_JALR_PC:  state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with the control bundle registered alongside it, so the
  // outputs come straight from flops decoded for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= state_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  // While reset is held the selects already show FETCH and every write
  // strobe is suppressed, so an aborted instruction never commits anything.
  assign ctrl_view = reset ? state_ctrl(S_FETCH) : ctrl_q;

  assign ALUOp         = ctrl_view.alu_op;
  assign ALUSrcA       = ctrl_view.src_a;
  assign ALUSrcB       = ctrl_view.src_b;
  assign ResultSrc     = ctrl_view.result_src;
  assign AdrSrc        = ctrl_view.adr_src;
  assign IRWrite       = ~reset & ctrl_view.fetch & ready;
  assign PCUpdate      = ~reset & (ctrl_view.pc_update | (ctrl_view.fetch & ready));
  assign Branch        = ~reset & ctrl_view.branch;
  assign RegWrite      = ~reset & ctrl_view.reg_write;
  assign MemWrite      = ~reset & ctrl_view.mem_write;
  assign illegal_instr = ~reset & ctrl_view.illegal;
  assign state         = reset ? S_FETCH : state_q;

endmodule
